// File: rtl/mem_word.sv
// mem_word: multi-lane word memory with byte/word access, a fixed
// multi-cycle access latency and a req/ready handshake. After reset the
// array is swept to zero one word per cycle and word 0 is loaded with a
// boot value; the array itself has no reset.
module mem_word #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LANES   = 2,
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned LATENCY = 3,
  parameter logic [LANES*LANE_W-1:0] INIT_WORD0 = (LANES*LANE_W)'(16'h0001)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      write,
  input  logic                      size,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [LANES*LANE_W-1:0]   in,
  output logic [LANES*LANE_W-1:0]   out,
  output logic                      ready,
  output logic                      busy
);

  localparam int unsigned W     = LANES * LANE_W;
  localparam int unsigned LG    = $clog2(LANES);
  localparam int unsigned IDX_W = ADDR_W - LG;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  ptr;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              size_q;
  logic              write_q;
  logic [W-1:0]      data_q;
  logic [IDX_W-1:0]  widx;
  logic              access;

  logic [W-1:0] mem [DEPTH];

  assign widx   = IDX_W'(addr_q >> LG);
  assign access = (state == S_WAIT) && (cnt == '0);
  assign ready  = (state == S_DONE);
  assign busy   = (state != S_IDLE);

  // Control FSM: clear sweep, request latch, latency countdown, read capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_CLEAR;
      ptr     <= '0;
      cnt     <= '0;
      out     <= '0;
      addr_q  <= '0;
      size_q  <= 1'b0;
      write_q <= 1'b1;
      data_q  <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= S_IDLE;
        end
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            size_q  <= size;
            write_q <= write;
            data_q  <= in;
            cnt     <= 4'(LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_DONE;
            if (write_q) out <= mem[widx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array writes: zero sweep with boot word on the last step, then
  // lane-masked writes on the access edge.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr] <= '0;
      if (ptr == '1) mem[0] <= INIT_WORD0;
    end else if (access && !write_q) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (size_q || ((addr_q & ADDR_W'(LANES - 1)) == ADDR_W'(k)))
          mem[widx][k*LANE_W +: LANE_W] <= data_q[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_mem_word.sv
// tb_mem_word: randomized and directed checks of mem_word against a
// byte-addressed reference model, for the default configuration and a
// 4-lane, latency-1 variant.
module tb_mem_word;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: ADDR_W=8, LANES=2, LATENCY=3
  logic        reset_a, req_a, write_a, size_a;
  logic [7:0]  addr_a;
  logic [15:0] din_a, dout_a;
  logic        ready_a, busy_a;

  // variant instance: ADDR_W=10, LANES=4, LATENCY=1
  logic        reset_b, req_b, write_b, size_b;
  logic [9:0]  addr_b;
  logic [31:0] din_b, dout_b;
  logic        ready_b, busy_b;

  mem_word dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .write(write_a), .size(size_a),
    .addr(addr_a), .in(din_a), .out(dout_a), .ready(ready_a), .busy(busy_a)
  );

  mem_word #(.ADDR_W(10), .LANES(4), .LANE_W(8), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .write(write_b), .size(size_b),
    .addr(addr_b), .in(din_b), .out(dout_b), .ready(ready_b), .busy(busy_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: plain byte arrays, little-endian lanes
  logic [7:0]  bytes_a [256];
  logic [15:0] ref_out_a;
  logic [7:0]  bytes_b [1024];
  logic [31:0] ref_out_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset_a();
    for (int i = 0; i < 256; i++) bytes_a[i] = 8'h00;
    bytes_a[0] = 8'h01;
    ref_out_a  = 16'h0000;
  endtask

  task automatic model_reset_b();
    for (int i = 0; i < 1024; i++) bytes_b[i] = 8'h00;
    bytes_b[0] = 8'h01;
    ref_out_b  = 32'h0;
  endtask

  // Count cycles busy stays high from the current sample; ready must stay low.
  task automatic sweep_a(output int cycles);
    bit saw_ready = 0;
    cycles = 0;
    while (busy_a && cycles < 1000) begin
      if (ready_a) saw_ready = 1;
      cycles++;
      step();
    end
    check("a_clear_no_ready", saw_ready, 0);
  endtask

  task automatic sweep_b(output int cycles);
    bit saw_ready = 0;
    cycles = 0;
    while (busy_b && cycles < 1000) begin
      if (ready_b) saw_ready = 1;
      cycles++;
      step();
    end
    check("b_clear_no_ready", saw_ready, 0);
  endtask

  // One access on instance A; checks latency, out, and the single ready pulse.
  task automatic acc_a(input bit wr_n, input bit sz, input logic [7:0] a, input logic [15:0] d);
    int lat;
    int base;
    req_a = 1; write_a = wr_n; size_a = sz; addr_a = a; din_a = d;
    step();
    req_a = 0;
    check("a_busy_after_accept", busy_a, 1);
    lat = 0;
    while (!ready_a && lat < 20) begin
      step();
      lat++;
    end
    check("a_latency", lat, 3);
    base = int'(a) & ~1;
    if (!wr_n) begin
      if (sz) begin
        bytes_a[base]   = d[7:0];
        bytes_a[base+1] = d[15:8];
      end else begin
        bytes_a[a] = a[0] ? d[15:8] : d[7:0];
      end
    end else begin
      ref_out_a = {bytes_a[base+1], bytes_a[base]};
    end
    check(wr_n ? "a_read_out" : "a_write_keeps_out", dout_a, ref_out_a);
    step();
    check("a_ready_one_cycle", ready_a, 0);
    check("a_idle_after_done", busy_a, 0);
  endtask

  task automatic acc_b(input bit wr_n, input bit sz, input logic [9:0] a, input logic [31:0] d);
    int lat;
    int base;
    req_b = 1; write_b = wr_n; size_b = sz; addr_b = a; din_b = d;
    step();
    req_b = 0;
    lat = 0;
    while (!ready_b && lat < 20) begin
      step();
      lat++;
    end
    check("b_latency", lat, 1);
    base = int'(a) & ~3;
    if (!wr_n) begin
      if (sz) begin
        for (int k = 0; k < 4; k++) bytes_b[base+k] = d[8*k +: 8];
      end else begin
        bytes_b[a] = d[8*a[1:0] +: 8];
      end
    end else begin
      ref_out_b = {bytes_b[base+3], bytes_b[base+2], bytes_b[base+1], bytes_b[base]};
    end
    check(wr_n ? "b_read_out" : "b_write_keeps_out", dout_b, ref_out_b);
    step();
    check("b_ready_one_cycle", ready_b, 0);
    check("b_idle_after_done", busy_b, 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    int pos [3];
    bit bad;

    reset_a = 0; req_a = 0; write_a = 1; size_a = 1; addr_a = '0; din_a = '0;
    reset_b = 0; req_b = 0; write_b = 1; size_b = 1; addr_b = '0; din_b = '0;

    // ---- clear / boot, with req held high through the sweep
    req_a = 1;
    step(); step(); step();
    check("a_reset_out", dout_a, 0);
    check("a_reset_ready", ready_a, 0);
    check("a_reset_busy", busy_a, 1);
    reset_a = 1;
    sweep_a(cyc);
    req_a = 0;
    check("a_clear_cycles", cyc, 128);
    model_reset_a();
    step();
    check("a_no_access_from_clear_req", busy_a, 0);

    acc_a(1, 1, 8'h00, 16'h0);
    check("a_boot_word", dout_a, 16'h0001);
    acc_a(1, 1, 8'h10, 16'h0);

    // ---- word and byte lanes
    acc_a(0, 1, 8'h20, 16'hBEEF);
    acc_a(1, 1, 8'h20, 16'h0);
    acc_a(1, 1, 8'h21, 16'h0);
    acc_a(0, 0, 8'h21, 16'h1200);
    acc_a(1, 1, 8'h20, 16'h0);
    check("a_lane1_merge", dout_a, 16'h12EF);
    acc_a(0, 0, 8'h20, 16'h0034);
    acc_a(1, 0, 8'h20, 16'h0);
    check("a_lane0_merge", dout_a, 16'h1234);

    // ---- req held continuously: pulses every LATENCY+2 cycles
    req_a = 1; write_a = 1; size_a = 1; addr_a = 8'h20;
    pulses = 0;
    for (int k = 1; k <= 30 && pulses < 3; k++) begin
      step();
      if (ready_a) begin
        pos[pulses] = k;
        pulses++;
      end
    end
    req_a = 0;
    check("a_hold_pulses", pulses, 3);
    check("a_hold_first", pos[0], 4);
    check("a_hold_spacing1", pos[1] - pos[0], 5);
    check("a_hold_spacing2", pos[2] - pos[1], 5);
    ref_out_a = {bytes_a[8'h21], bytes_a[8'h20]};
    check("a_hold_out", dout_a, ref_out_a);
    step(); step();
    check("a_hold_no_extra", busy_a, 0);

    // ---- randomized accesses against the byte model
    for (int i = 0; i < 60; i++) begin
      acc_a(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
    end

    // ---- reset in the middle of a write
    req_a = 1; write_a = 0; size_a = 1; addr_a = 8'h40; din_a = 16'hAAAA;
    step();
    req_a = 0;
    step();
    reset_a = 0;
    #1;
    check("a_abort_ready", ready_a, 0);
    check("a_abort_out", dout_a, 0);
    bad = 0;
    step(); if (ready_a) bad = 1;
    step(); if (ready_a) bad = 1;
    check("a_abort_ready_in_reset", bad, 0);
    reset_a = 1;
    sweep_a(cyc);
    check("a_clear_cycles_again", cyc, 128);
    model_reset_a();
    acc_a(1, 1, 8'h40, 16'h0);
    check("a_aborted_write_absent", dout_a, 16'h0000);

    // ---- variant instance
    step();
    check("b_reset_busy", busy_b, 1);
    check("b_reset_out", dout_b, 0);
    reset_b = 1;
    sweep_b(cyc);
    check("b_clear_cycles", cyc, 256);
    model_reset_b();
    acc_b(1, 1, 10'h000, 32'h0);
    check("b_boot_word", dout_b, 32'h0000_0001);
    acc_b(0, 0, 10'h203, 32'hAB00_0000);
    acc_b(1, 1, 10'h200, 32'h0);
    check("b_lane3_write", dout_b, 32'hAB00_0000);
    for (int i = 0; i < 40; i++) begin
      acc_b(1'($urandom), 1'($urandom), 10'($urandom), 32'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
